// File: rtl/intc_nested_pkg.sv
// Shared CPU-side constants for the nested interrupt controller: vector numbers and FSM state type.
package intc_nested_pkg;

    localparam int VEC_OVF_ALU   = 1;
    localparam int VEC_OVF_STACK = 2;
    localparam int VEC_CH_BASE   = 3;
    localparam int N_FAULT       = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } intc_state_t;

    // Source index 0/1 are the faults, index N_FAULT+i is external channel i.
    function automatic int src_to_vec(input int src);
        if (src == 0) begin
            return VEC_OVF_ALU;
        end else if (src == 1) begin
            return VEC_OVF_STACK;
        end else begin
            return VEC_CH_BASE + src - N_FAULT;
        end
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of req wins.
module intc_prio_enc #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/intc_nested.sv
// Nested vectored interrupt controller: edge/level channels plus two non-maskable faults,
// a priority-ordered nesting stack and an IDLE/REQ request FSM towards the control unit.
module intc_nested
    import intc_nested_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int VEC_W = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   irq,
    input  logic [N_SRC-1:0]   edge_mode,
    input  logic [N_SRC-1:0]   mask,
    input  logic               ovf_alu,
    input  logic               ovf_stack,
    input  logic               int_ack,
    input  logic               reti,
    output logic               int_req,
    output logic [VEC_W-1:0]   int_vec,
    output logic [N_SRC+1:0]   in_service,
    output logic               nest_full,
    output logic               nest_err,
    output intc_state_t        dbg_state
);

    localparam int NS  = N_SRC + N_FAULT;
    localparam int IW  = $clog2(NS);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [1:0]       fault_q;
    logic [N_SRC-1:0] irq_prev, pend_edge, pend_lvl, ack_clr;
    logic             hist_valid;
    logic [IW-1:0]    stack_q [DEPTH];
    logic [SPW-1:0]   sp_q, top_ptr, wr_ptr;
    logic             nest_err_q;

    intc_state_t      state_q, state_d;
    logic [IW-1:0]    cur_q, cur_d;

    logic [NS-1:0]    pending, enabled, elig;
    logic [IW-1:0]    top_idx, cand_idx;
    logic             empty, full, cand_valid, pop, push;

    assign pending = {(edge_mode & pend_edge) | (~edge_mode & pend_lvl), fault_q};
    assign enabled = {~mask, 2'b11};
    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SPW'(DEPTH));
    assign top_ptr = sp_q - SPW'(1);

    // Stack grows upward with strictly rising priority, so the top entry is the one to beat.
    always_comb begin
        top_idx    = '0;
        in_service = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (SPW'(k) == top_ptr) top_idx = stack_q[k];
            if (SPW'(k) < sp_q) in_service[stack_q[k]] = 1'b1;
        end
    end

    always_comb begin
        elig = '0;
        for (int j = 0; j < NS; j++) begin
            elig[j] = pending[j] & enabled[j] & ~in_service[j]
                    & (empty | (IW'(j) < top_idx))
                    & ((j < N_FAULT) | ~full);
        end
    end

    intc_prio_enc #(.W(NS), .IW(IW)) u_prio (
        .req   (elig),
        .valid (cand_valid),
        .idx   (cand_idx)
    );

    // Handshake: int_req/int_vec is the offer; int_ack takes it only in a cycle with int_req=1,
    // and a take is refused while the stack is full unless a reti frees a slot in the same cycle.
    assign pop    = reti & ~empty;
    assign push   = int_ack & (state_q == ST_REQ) & (~full | pop);
    assign wr_ptr = pop ? top_ptr : sp_q;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr[i] = push & (cur_q == IW'(i + N_FAULT));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q    <= '0;
            irq_prev   <= '0;
            hist_valid <= 1'b0;
            pend_edge  <= '0;
            pend_lvl   <= '0;
            sp_q       <= '0;
            nest_err_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) stack_q[k] <= '0;
        end else begin
            fault_q    <= {ovf_stack, ovf_alu};
            irq_prev   <= irq;
            hist_valid <= 1'b1;
            pend_lvl   <= irq;
            // History is untrusted on the first edge after reset, so lines already high are not edges.
            pend_edge  <= (pend_edge & ~ack_clr)
                        | (edge_mode & irq & ~irq_prev & {N_SRC{hist_valid}});
            if (reti && empty) nest_err_q <= 1'b1;
            sp_q <= sp_q - SPW'(pop) + SPW'(push);
            for (int k = 0; k < DEPTH; k++) begin
                if (push && (SPW'(k) == wr_ptr)) stack_q[k] <= cur_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    // The best candidate never ranks below the current one while it stays eligible,
    // so tracking it keeps int_vec stable except for a strictly higher preemptor.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            ST_IDLE: begin
                if (cand_valid) begin
                    state_d = ST_REQ;
                    cur_d   = cand_idx;
                end
            end
            ST_REQ: begin
                if (push || !cand_valid) state_d = ST_IDLE;
                else                     cur_d   = cand_idx;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        int_req   = (state_q == ST_REQ);
        int_vec   = int_req ? VEC_W'(src_to_vec(int'(cur_q))) : '0;
        nest_full = full;
        nest_err  = nest_err_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_intc_nested.sv
// Bench for intc_nested: directed scenarios plus randomized traffic against a queue-based model.
module tb_intc_nested;
    import intc_nested_pkg::*;

    localparam int N_SRC = 8;
    localparam int VEC_W = 8;
    localparam int DEPTH = 4;
    localparam int NS    = N_SRC + 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_SRC-1:0]   irq, edge_mode, mask;
    logic               ovf_alu, ovf_stack, int_ack, reti;
    logic               int_req;
    logic [VEC_W-1:0]   int_vec;
    logic [N_SRC+1:0]   in_service;
    logic               nest_full, nest_err;
    intc_state_t        dbg_state;

    int tests = 0;
    int fails = 0;

    intc_nested #(.N_SRC(N_SRC), .VEC_W(VEC_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .edge_mode  (edge_mode),
        .mask       (mask),
        .ovf_alu    (ovf_alu),
        .ovf_stack  (ovf_stack),
        .int_ack    (int_ack),
        .reti       (reti),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .in_service (in_service),
        .nest_full  (nest_full),
        .nest_err   (nest_err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: sources numbered by priority (0 = ovf_alu, 1 = ovf_stack, 2+i = channel i),
    // vector = number + 1, nesting stack kept as a queue of source numbers.
    bit [N_SRC-1:0] m_prev, m_pe, m_lvl;
    bit [1:0]       m_fault;
    bit             m_hist, m_req, m_err;
    int             m_cur;
    int             m_stk[$];

    task automatic model_reset();
        m_prev = '0; m_pe = '0; m_lvl = '0; m_fault = '0;
        m_hist = 0; m_req = 0; m_err = 0; m_cur = 0;
        m_stk.delete();
    endtask

    function automatic bit m_in_stk(int j);
        foreach (m_stk[k]) if (m_stk[k] == j) return 1;
        return 0;
    endfunction

    task automatic model_edge();
        int  cand = -1;
        bit  ack_ok, old_req, pend, ok;
        int  old_cur;
        for (int j = 0; j < NS; j++) begin
            if (j < 2) pend = m_fault[j];
            else       pend = edge_mode[j-2] ? m_pe[j-2] : m_lvl[j-2];
            ok = pend && (j < 2 || !mask[j-2]) && !m_in_stk(j)
                 && (m_stk.size() == 0 || j < m_stk[$])
                 && (j < 2 || m_stk.size() < DEPTH);
            if (ok && cand < 0) cand = j;
        end
        ack_ok  = int_ack && m_req && (m_stk.size() < DEPTH || (reti && m_stk.size() > 0));
        old_req = m_req;
        old_cur = m_cur;
        if (reti) begin
            if (m_stk.size() == 0) m_err = 1;
            else void'(m_stk.pop_back());
        end
        if (ack_ok) m_stk.push_back(old_cur);
        if (!old_req) begin
            m_req = (cand >= 0);
            if (m_req) m_cur = cand;
        end else if (ack_ok || cand < 0) begin
            m_req = 0;
        end else begin
            m_cur = cand;
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (ack_ok && old_cur == i + 2) m_pe[i] = 0;
            if (edge_mode[i] && m_hist && irq[i] && !m_prev[i]) m_pe[i] = 1;
        end
        m_lvl   = irq;
        m_prev  = irq;
        m_hist  = 1;
        m_fault = {ovf_stack, ovf_alu};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [N_SRC+1:0] svc = '0;
        foreach (m_stk[k]) svc[m_stk[k]] = 1'b1;
        chk("int_req", int_req, m_req);
        chk("int_vec", int_vec, m_req ? m_cur + 1 : 0);
        chk("in_service", in_service, svc);
        chk("nest_full", nest_full, m_stk.size() == DEPTH);
        chk("nest_err", nest_err, m_err);
        chk("dbg_state", dbg_state, m_req ? ST_REQ : ST_IDLE);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_edge();
        else       model_reset();
        #1;
        check_all();
    endtask

    // Raise a channel for one cycle, confirm its request, then acknowledge it.
    task automatic take(input int ch);
        irq[ch] = 1'b1;
        tick();
        irq[ch] = 1'b0;
        tick();
        chk("take_req", int_req, 1);
        chk("take_vec", int_vec, ch + 3);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("take_svc", in_service[ch+2], 1);
    endtask

    initial begin
        reset = 1'b0; irq = '0; edge_mode = '1; mask = '0;
        ovf_alu = 1'b0; ovf_stack = 1'b0; int_ack = 1'b0; reti = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_req", int_req, 0);
        chk("rst_vec", int_vec, 0);
        chk("rst_svc", in_service, 0);
        chk("rst_err", nest_err, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Single edge pulse on channel 3: latency and acknowledge.
        irq[3] = 1'b1;
        tick();
        irq[3] = 1'b0;
        chk("lat_e0", int_req, 0);
        tick();
        chk("ch3_req", int_req, 1);
        chk("ch3_vec", int_vec, 6);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("ch3_svc", in_service[5], 1);
        chk("ch3_req_drop", int_req, 0);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("ch3_popped", in_service, 0);

        // Channel 5 in service, channel 1 preempts.
        take(5);
        take(1);
        chk("nest_svc", in_service, 10'h088);
        reti = 1'b1;
        tick();
        tick();
        reti = 1'b0;
        chk("nest_empty", in_service, 0);
        chk("nest_no_err", nest_err, 0);

        // Channels 2 and 6 together: 2 wins, 6 follows after return.
        irq = 8'b0100_0100;
        tick();
        irq = '0;
        tick();
        chk("pair_first", int_vec, 5);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        tick();
        chk("pair_blocked", int_req, 0);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        tick();
        chk("pair_second_req", int_req, 1);
        chk("pair_second", int_vec, 9);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        reti = 1'b1;
        tick();
        reti = 1'b0;

        // Return with empty stack.
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("err_set", nest_err, 1);
        tick();
        chk("err_hold", nest_err, 1);

        // Fill the stack, then channel requests are held off but a fault still requests.
        take(7);
        take(6);
        take(5);
        take(4);
        chk("full", nest_full, 1);
        irq[0] = 1'b1;
        tick();
        irq[0] = 1'b0;
        tick();
        tick();
        chk("full_no_ch", int_req, 0);
        ovf_alu = 1'b1;
        tick();
        tick();
        chk("fault_req", int_req, 1);
        chk("fault_vec", int_vec, 1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("fault_ack_ignored", int_req, 1);
        chk("fault_no_push", in_service, 10'h3C0);
        ovf_alu = 1'b0;
        tick();
        tick();
        chk("fault_gone", int_req, 0);
        reti = 1'b1;
        tick();
        tick();
        reti = 1'b0;
        tick();
        chk("ch0_after_pop", int_vec, 3);
        chk("two_levels", in_service, 10'h300);
        chk("err_still", nest_err, 1);

        // Asynchronous reset while requesting with two levels nested; lines held high across release.
        irq = 8'b0001_0010;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_req", int_req, 0);
        chk("arst_vec", int_vec, 0);
        chk("arst_svc", in_service, 0);
        chk("arst_full", nest_full, 0);
        chk("arst_err", nest_err, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("release_no_req", int_req, 0);
        irq = '0;
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if (n % 256 == 0) edge_mode = N_SRC'($urandom);
            irq       = N_SRC'($urandom & $urandom & $urandom);
            mask      = N_SRC'($urandom & $urandom & $urandom);
            ovf_alu   = ($urandom_range(0, 31) == 0);
            ovf_stack = ($urandom_range(0, 31) == 0);
            int_ack   = ($urandom_range(0, 2) == 0);
            reti      = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                check_all();
                tick();
                reset = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/intc_nested.md
INTC_NESTED -- requirements
Module: intc_nested

Interface
REQ-001 Parameter N_SRC, default 8: number of external interrupt channels, 1..29.
REQ-002 Parameter VEC_W, default 8: vector width handed to the control unit.
REQ-003 Parameter DEPTH, default 4: maximum interrupt nesting levels, 1..8.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 irq  in  N_SRC  external requests; bit i is channel i.
REQ-007 edge_mode  in  N_SRC  per channel: 1 = rising-edge latched, 0 = level.
REQ-008 mask  in  N_SRC  per channel: 1 = disabled.
REQ-009 ovf_alu, ovf_stack  in  1 each  non-maskable fault requests, level.
REQ-010 int_ack  in  1  control unit accepted the current vector (call taken).
REQ-011 reti  in  1  control unit executed return-from-interrupt.
REQ-012 int_req  out  1  interrupt request to the control unit.
REQ-013 int_vec  out  VEC_W  vector of the requested source; 0 when int_req=0.
REQ-014 in_service  out  N_SRC+2  one bit per source currently on the nesting stack.
REQ-015 nest_full  out  1  nesting stack holds DEPTH entries.
REQ-016 nest_err  out  1  sticky: reti received with empty stack.

Function
REQ-017 Vectors SHALL be: ovf_alu=1, ovf_stack=2, channel i = i+3.
REQ-018 Priority SHALL be ovf_alu > ovf_stack > channel 0 > ... > channel N_SRC-1.
REQ-019 Edge channel: pending bit set on the edge where irq=1 and previous sample=0; cleared only by int_ack of that vector.
REQ-020 Level channel: pending bit equals irq from the previous edge; never cleared by int_ack.
REQ-021 Faults SHALL be sampled as level sources and ignore mask.
REQ-022 Candidate = highest-priority pending source with mask clear, not in in_service, and strictly higher priority than the stack top (any source if stack empty).
REQ-023 State machine IDLE/REQ: IDLE -> REQ on the edge after a candidate exists; REQ -> IDLE on int_ack or when no candidate remains.
REQ-024 Latency: edge seen at edge E0 sets pending at E0; int_req=1 after E1.
REQ-025 In REQ, int_vec SHALL stay stable unless a strictly higher-priority candidate appears; it is then replaced on the next edge.
REQ-026 int_ack while int_req=1 SHALL push int_vec onto the stack, set its in_service bit and return to IDLE; int_ack while int_req=0 is ignored.
REQ-027 reti SHALL pop the stack top and clear its in_service bit; reti on empty stack sets nest_err and changes nothing else.
REQ-028 Simultaneous reti and int_ack: pop first, then push; depth unchanged.
REQ-029 While nest_full=1, int_req SHALL remain 0 for channels; faults still request, and their int_ack is ignored (no push) while full.
REQ-030 A channel masked while in REQ SHALL drop int_req on the next edge if no other candidate exists.

Reset
REQ-031 reset low SHALL asynchronously clear pending, edge history, stack, in_service, nest_err, int_req, int_vec and force IDLE, including mid-REQ or while nested.
REQ-032 The first edge after reset release SHALL not detect edges on channels already high at release.

Structure
REQ-033 Vector constants (VEC_OVF_ALU, VEC_OVF_STACK, VEC_CH_BASE) and the IDLE/REQ state type SHALL live in the shared CPU package, so the control unit uses the same values.
REQ-034 The combinational priority selection SHALL be a sub-module intc_prio_enc, parametrised by width.

Verification
REQ-035 Edge channel 3 pulses one cycle, mask=0 -> int_req=1, int_vec=6 two edges later; int_ack -> in_service[ch3] set, int_req=0.
REQ-036 Channel 5 in service, channel 1 rises -> preempts with int_vec=4; reti twice -> stack empty, nest_err=0.
REQ-037 Channels 2 and 6 requested in the same cycle -> int_vec=5 first; after its ack and reti -> int_vec=9.
REQ-038 DEPTH=4, four nested acks -> nest_full=1; new channel request -> int_req stays 0; ovf_alu=1 -> int_req=1, int_vec=1.
REQ-039 reti with empty stack -> nest_err=1, held until reset low.
REQ-040 reset low asserted during REQ with two levels nested -> all outputs 0 immediately; irq held high across release -> no request from edge channels.
